// File: rtl/updown_counter.sv
// Parametrised up/down event counter with wrap/saturate, terminal-count pulse and sticky overflow.
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN.
module updown_counter #(
   parameter int             WIDTH     = 8,
   parameter logic [WIDTH-1:0] MAX_VAL   = '1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit             SATURATE  = 1'b0,
   parameter int             PRESC_DIV = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clear,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             ovf
);

   localparam bit CFG_OK = (WIDTH >= 2) && (WIDTH <= 32) && (MAX_VAL >= 1) &&
                           (RESET_VAL <= MAX_VAL) && (PRESC_DIV >= 2);

   if (!CFG_OK) begin : g_bad_cfg
      $error("updown_counter: illegal parameter combination");
   end

   logic [WIDTH-1:0] out_q, out_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             step;

`ifdef COUNTER_PRESCALE_EN
   localparam int PW = $clog2(PRESC_DIV);
   logic [PW-1:0] presc_q, presc_d;

   // Prescaler wraps at PRESC_DIV-1, which is the only cycle the counter may advance.
   always_comb begin
      presc_d = presc_q;
      step    = 1'b0;
      if (enable) begin
         if (presc_q == PW'(PRESC_DIV - 1)) begin
            presc_d = '0;
            step    = 1'b1;
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
      if (clear || load) presc_d = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) presc_q <= '0;
      else       presc_q <= presc_d;
   end
`else
   assign step = enable;
`endif

   always_comb begin
      out_d = out_q;
      tc_d  = 1'b0;
      ovf_d = ovf_q;
      if (clear) begin
         out_d = RESET_VAL;
         ovf_d = 1'b0;
      end else if (load) begin
         out_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      end else if (step) begin
         if (up_dn) begin
            if (out_q == MAX_VAL) begin
               out_d = SATURATE ? MAX_VAL : '0;
               tc_d  = 1'b1;
               ovf_d = 1'b1;
            end else begin
               out_d = out_q + WIDTH'(1);
            end
         end else begin
            if (out_q == '0) begin
               out_d = SATURATE ? '0 : MAX_VAL;
               tc_d  = 1'b1;
               ovf_d = 1'b1;
            end else begin
               out_d = out_q - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q <= RESET_VAL;
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         out_q <= out_d;
         tc_q  <= tc_d;
         ovf_q <= ovf_d;
      end
   end

   assign out = out_q;
   assign tc  = tc_q;
   assign ovf = ovf_q;

endmodule
